sr_ctrl_rev3: RTL

SR_CTRL_REV3 -- requirements
Module: sr_ctrl_rev3

---
 rtl/sr_ctrl_rev3.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sr_ctrl_rev3.sv
// Serial LED-chain encoder: each word becomes ONE/DATA/ZERO slots, frames end with an all-zero RST period.
// Optional underrun counter enabled by defining SR_CTRL_UNDERRUN_CNT_EN.
module sr_ctrl_rev3 #(
  parameter int WIDTH       = 8,
  parameter int RESET_SLOTS = 64,
  parameter int CNT_W       = 16
) (
  input  logic             sr_clk,
  input  logic             ar,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  input  logic             data_last,
  output logic             data_ready,
  output logic             ser_out,
  output logic             sr_latch,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] underrun_cnt
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RST_W = $clog2(RESET_SLOTS + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_SLOTS - 1);

  typedef enum logic [2:0] {IDLE, ONE, DATA, ZERO, RST} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             last_r_q, last_r_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             sr_latch_q, sr_latch_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;

  logic slot_end;
  logic accept;

  assign slot_end   = (idx_q == IDX_LAST);
  assign data_ready = (state_q == IDLE) || ((state_q == ZERO) && slot_end);
  assign accept     = data_valid && data_ready;

  always_comb begin
    state_d      = state_q;
    idx_d        = slot_end ? '0 : idx_q + 1'b1;
    hold_d       = hold_q;
    last_r_d     = last_r_q;
    rst_cnt_d    = rst_cnt_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (accept) begin
          state_d  = ONE;
          hold_d   = data_in;
          last_r_d = data_last;
        end
      end
      ONE:  if (slot_end) state_d = DATA;
      DATA: if (slot_end) state_d = ZERO;
      ZERO: begin
        // A word offered on the final ZERO cycle chains straight on, skipping RST
        if (slot_end) begin
          if (accept) begin
            state_d  = ONE;
            hold_d   = data_in;
            last_r_d = data_last;
          end else begin
            state_d   = RST;
            rst_cnt_d = '0;
          end
        end
      end
      RST: begin
        if (slot_end) begin
          if (rst_cnt_q == RST_LAST) begin
            state_d      = IDLE;
            rst_cnt_d    = '0;
            frame_done_d = 1'b1;
          end else begin
            rst_cnt_d = rst_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    // Outputs are derived from the next state so the registers line up with it
    case (state_d)
      ONE:     ser_out_d = 1'b1;
      DATA:    ser_out_d = hold_d[idx_d];
      default: ser_out_d = 1'b0;
    endcase
    busy_d     = (state_d != IDLE);
    sr_latch_d = (state_d != IDLE) && (idx_d == IDX_LAST);
  end

  always_ff @(posedge sr_clk) begin
    if (ar) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      hold_q       <= '0;
      last_r_q     <= 1'b0;
      rst_cnt_q    <= '0;
      ser_out_q    <= 1'b0;
      sr_latch_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      last_r_q     <= last_r_d;
      rst_cnt_q    <= rst_cnt_d;
      ser_out_q    <= ser_out_d;
      sr_latch_q   <= sr_latch_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ser_out    = ser_out_q;
  assign sr_latch   = sr_latch_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

`ifdef SR_CTRL_UNDERRUN_CNT_EN
  logic             under_inc;
  logic [CNT_W-1:0] underrun_q, underrun_d;

  assign under_inc = (state_q == ZERO) && slot_end && !accept && !last_r_q;

  always_comb begin
    underrun_d = underrun_q;
    if (under_inc && (underrun_q != '1)) underrun_d = underrun_q + 1'b1;
  end

  always_ff @(posedge sr_clk) begin
    if (ar) underrun_q <= '0;
    else    underrun_q <= underrun_d;
  end

  assign underrun_cnt = underrun_q;
`else
  assign underrun_cnt = '0;
`endif

endmodule
